// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 18-bit multiply/divide unit. It accepts one request
// while idle, runs a fixed WIDTH-cycle shift-add or restoring-divide loop, and
// issues a single-cycle register-file write with the result.
//
// Handshake: START is the request valid and !BUSY is the ready. A request is
// accepted on a rising edge where START=1 and BUSY=0. BUSY stays high from
// that edge until the write cycle (DONE) has completed. START while BUSY=1 is
// dropped and never queued. The write strobe REG_WRITE_ENABLE has no
// back-pressure; the register file captures it on the edge that ends DONE.
module mul_div_unit #(
  parameter int WIDTH          = 18,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      CPU_CLOCK,
  input  logic                      CLEAR,
  input  logic                      START,
  input  logic [1:0]                OP,
  input  logic [WIDTH-1:0]          OPERAND_A,
  input  logic [WIDTH-1:0]          OPERAND_B,
  input  logic [REG_ADDR_WIDTH-1:0] DEST_REG,
  output logic                      BUSY,
  output logic [REG_ADDR_WIDTH-1:0] WRITE_REG,
  output logic [WIDTH-1:0]          WRITE_DATA,
  output logic                      REG_WRITE_ENABLE,
  output logic                      DIV_BY_ZERO,
  output logic [1:0]                STATE_DEBUG
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

  state_t                      state;
  state_t                      state_next;

  // Latched request; the live inputs may change after acceptance.
  logic [1:0]                  op_q;
  logic [WIDTH-1:0]            a_q;
  logic [WIDTH-1:0]            b_q;
  logic [REG_ADDR_WIDTH-1:0]   dest_q;
  logic                        dz_q;
  logic [CW-1:0]               cnt;

  // Shared accumulator pair.
  //   MUL/MULH: acc_hi = running high product (top bit always 0),
  //             acc_lo = multiplier shifting out / low product shifting in.
  //   DIV/REM : acc_hi = partial remainder, acc_lo = dividend shifting out /
  //             quotient bits shifting in.
  logic [WIDTH:0]              acc_hi;
  logic [WIDTH-1:0]            acc_lo;

  logic                        is_div_req;
  logic                        dz_req;

  logic [WIDTH:0]              mul_sum;
  logic [WIDTH:0]              mul_hi_next;
  logic [WIDTH-1:0]            mul_lo_next;
  logic [WIDTH:0]              rem_shift;
  logic [WIDTH:0]              div_diff;
  logic                        div_ok;
  logic [WIDTH:0]              div_hi_next;
  logic [WIDTH-1:0]            div_lo_next;
  logic [WIDTH:0]              hi_next;
  logic [WIDTH-1:0]            lo_next;
  logic [WIDTH-1:0]            iter_result;

  assign is_div_req = OP[1];
  assign dz_req     = is_div_req && (OPERAND_B == '0);

  // State register; CLEAR wins over any same-edge request.
  always_ff @(posedge CPU_CLOCK) begin
    if (CLEAR) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: divide-by-zero skips the iteration loop entirely.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_next = dz_req ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST_ITER) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide, selected by op.
  always_comb begin
    mul_sum     = acc_hi + {1'b0, (acc_lo[0] ? a_q : '0)};
    mul_hi_next = {1'b0, mul_sum[WIDTH:1]};
    mul_lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};

    rem_shift   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_ok      = (rem_shift >= {1'b0, b_q});
    div_diff    = rem_shift - {1'b0, b_q};
    div_hi_next = div_ok ? div_diff : rem_shift;
    div_lo_next = {acc_lo[WIDTH-2:0], div_ok};

    hi_next     = op_q[1] ? div_hi_next : mul_hi_next;
    lo_next     = op_q[1] ? div_lo_next : mul_lo_next;

    case (op_q)
      2'b00:   iter_result = lo_next;
      2'b01:   iter_result = hi_next[WIDTH-1:0];
      2'b10:   iter_result = lo_next;
      default: iter_result = hi_next[WIDTH-1:0];
    endcase
  end

  // Datapath: latch on accept, iterate in RUN, load the write port on DONE entry.
  always_ff @(posedge CPU_CLOCK) begin
    if (CLEAR) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dest_q     <= '0;
      dz_q       <= 1'b0;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      WRITE_DATA <= '0;
      WRITE_REG  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            op_q   <= OP;
            a_q    <= OPERAND_A;
            b_q    <= OPERAND_B;
            dest_q <= DEST_REG;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= is_div_req ? OPERAND_A : OPERAND_B;
            dz_q   <= dz_req;
            if (dz_req) begin
              // Quotient saturates to all ones; remainder is the dividend.
              WRITE_DATA <= OP[0] ? OPERAND_A : '1;
              WRITE_REG  <= DEST_REG;
            end
          end
        end
        S_RUN: begin
          acc_hi <= hi_next;
          acc_lo <= lo_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            WRITE_DATA <= iter_result;
            WRITE_REG  <= dest_q;
          end
        end
        S_DONE: begin
          dz_q <= 1'b0;
        end
        default: begin
          dz_q <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY             = (state != S_IDLE);
  assign REG_WRITE_ENABLE = (state == S_DONE);
  assign DIV_BY_ZERO      = (state == S_DONE) && dz_q;
  assign STATE_DEBUG      = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit. A cycle-level latency
// model plus plain-arithmetic results predicts every output on every cycle;
// directed tasks additionally pin hand-computed results and latencies.
module tb_mul_div_unit;

  localparam int W  = 18;
  localparam int RA = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [RA-1:0] dest;
  logic          busy;
  logic [RA-1:0] wreg;
  logic [W-1:0]  wdata;
  logic          rwe;
  logic          dbz;
  logic [1:0]    st_dbg;

  mul_div_unit #(.WIDTH(W), .REG_ADDR_WIDTH(RA)) dut (
    .CPU_CLOCK        (clk),
    .CLEAR            (clear),
    .START            (start),
    .OP               (op),
    .OPERAND_A        (a),
    .OPERAND_B        (b),
    .DEST_REG         (dest),
    .BUSY             (busy),
    .WRITE_REG        (wreg),
    .WRITE_DATA       (wdata),
    .REG_WRITE_ENABLE (rwe),
    .DIV_BY_ZERO      (dbz),
    .STATE_DEBUG      (st_dbg)
  );

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  bit checking = 1'b0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_result(input logic [1:0] o,
                                                input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == '0) ? {W{1'b1}} : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Model state: cycles left until idle; the write appears when one is left.
  bit            m_busy    = 1'b0;
  int            m_left    = 0;
  logic [W-1:0]  m_wd      = '0;
  logic [RA-1:0] m_wr      = '0;
  logic [W-1:0]  m_pend_wd = '0;
  logic [RA-1:0] m_pend_wr = '0;
  bit            m_pend_dz = 1'b0;

  always @(posedge clk) begin
    if (clear) begin
      m_busy = 1'b0;
      m_left = 0;
      m_wd   = '0;
      m_wr   = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy    = 1'b1;
        m_pend_dz = op[1] && (b == '0);
        m_pend_wd = model_result(op, a, b);
        m_pend_wr = dest;
        m_left    = m_pend_dz ? 1 : W + 1;
        exp_q.push_back(m_pend_wd);
      end
    end else begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    if (m_busy && m_left == 1) begin
      m_wd = m_pend_wd;
      m_wr = m_pend_wr;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("busy",  W'(busy), W'(m_busy));
      check("rwe",   W'(rwe),  W'(m_busy && m_left == 1));
      check("dbz",   W'(dbz),  W'(m_busy && m_left == 1 && m_pend_dz));
      check("wdata", wdata,    m_wd);
      check("wreg",  W'(wreg), W'(m_wr));
      if (rwe) begin
        n_strobe++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_strobe", W'(1), W'(0));
        end else begin
          check("sb_data", wdata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entry/exit invariant: 1 time unit after a rising edge.
  task automatic do_op(input string name, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [RA-1:0] d, input logic [W-1:0] want,
                       input bit want_dz, input int want_lat, input bit poke);
    int            lat;
    logic [W-1:0]  got;
    logic [RA-1:0] got_r;
    logic          got_z;
    lat   = 0;
    got   = '0;
    got_r = '0;
    got_z = 1'b0;
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom_range(0, 262143));
    b = W'($urandom_range(0, 262143));
    op = 2'($urandom_range(0, 3));
    dest = RA'($urandom_range(0, 15));
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rwe) begin
        lat = n; got = wdata; got_r = wreg; got_z = dbz;
        if (poke) start = 1'b1;
        break;
      end
      start = poke && (n == 3 || n == 18);
      if (start) begin
        a = W'($urandom_range(1, 262143));
        b = W'($urandom_range(1, 262143));
        op = 2'($urandom_range(0, 3));
      end
    end
    check({name, "_strobe_seen"}, W'(lat != 0), W'(1));
    check({name, "_latency"}, W'(lat), W'(want_lat));
    check({name, "_data"}, got, want);
    check({name, "_reg"}, W'(got_r), W'(d));
    check({name, "_dz"}, W'(got_z), W'(want_dz));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int s0;

  initial begin
    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;
    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    check("rst_busy",  W'(busy),  W'(0));
    check("rst_rwe",   W'(rwe),   W'(0));
    check("rst_wdata", wdata,     W'(0));
    clear = 1'b0;
    @(posedge clk); #1;

    do_op("mul_3x5",     2'd0, W'(3),       W'(5),       4'd7, W'(15),       1'b0, 19, 1'b0);
    do_op("mul_max",     2'd0, 18'h3FFFF,   18'h3FFFF,   4'd1, 18'h00001,    1'b0, 19, 1'b0);
    do_op("mulh_max",    2'd1, 18'h3FFFF,   18'h3FFFF,   4'd2, 18'h3FFFE,    1'b0, 19, 1'b0);
    do_op("mul_by_zero", 2'd0, W'(1234),    W'(0),       4'd3, W'(0),        1'b0, 19, 1'b0);
    do_op("div_100_7",   2'd2, W'(100),     W'(7),       4'd3, W'(14),       1'b0, 19, 1'b0);
    do_op("rem_100_7",   2'd3, W'(100),     W'(7),       4'd4, W'(2),        1'b0, 19, 1'b0);
    do_op("div_5_9",     2'd2, W'(5),       W'(9),       4'd0, W'(0),        1'b0, 19, 1'b0);
    do_op("rem_5_9",     2'd3, W'(5),       W'(9),       4'd5, W'(5),        1'b0, 19, 1'b0);
    do_op("div_by_zero", 2'd2, 18'h12345,   W'(0),       4'd6, 18'h3FFFF,    1'b1, 1,  1'b0);
    do_op("rem_by_zero", 2'd3, 18'h12345,   W'(0),       4'd8, 18'h12345,    1'b1, 1,  1'b0);

    // Requests during a busy operation (cycles 3, 18 and DONE) are dropped.
    s0 = n_strobe;
    do_op("mul_ignore",  2'd0, W'(21),      W'(13),      4'd9, W'(273),      1'b0, 19, 1'b1);
    repeat (25) @(posedge clk);
    #1;
    check("ignore_one_strobe", W'(n_strobe - s0), W'(1));

    // Abort mid-operation.
    s0 = n_strobe;
    op = 2'd0; a = W'(77); b = W'(88); dest = 4'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort_busy",  W'(busy), W'(0));
    check("abort_rwe",   W'(rwe),  W'(0));
    check("abort_wdata", wdata,    W'(0));
    check("abort_wreg",  W'(wreg), W'(0));
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_strobe", W'(n_strobe - s0), W'(0));

    // START on the same edge as CLEAR is not accepted.
    op = 2'd0; a = W'(2); b = W'(2); dest = 4'd1; start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    check("clr_start_busy", W'(busy), W'(0));
    repeat (3) @(posedge clk);
    #1;

    do_op("rem_after_clr", 2'd3, W'(1000),  W'(33),      4'd2, W'(10),       1'b0, 19, 1'b0);

    // Back-to-back: second request in the first idle cycle.
    s0 = n_strobe;
    do_op("b2b_mul",     2'd0, W'(6),       W'(7),       4'd10, W'(42),      1'b0, 19, 1'b0);
    do_op("b2b_div",     2'd2, 18'h3FFFF,   W'(3),       4'd11, 18'h15555,   1'b0, 19, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_two_strobes", W'(n_strobe - s0), W'(2));
    check("sb_drained", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 18-bit multiply/divide execution unit for the CPU datapath. It consumes the two operands read from the register file, computes one of four multiply/divide results over a fixed number of cycles, and produces a single-cycle register write (`WRITE_REG`, `WRITE_DATA`, `REG_WRITE_ENABLE`) that drives the register file's write port directly. While the unit is busy, the control unit stalls on `BUSY`.

## Interface
- `WIDTH`, 18, operand/result width in bits; equals the register width.
- `REG_ADDR_WIDTH`, 4, register index width (16 registers).

Ports:
- `CPU_CLOCK`  in  1  the single clock; all state updates on its rising edge.
- `CLEAR`  in  1  reset, synchronous and active-high.
- `START`  in  1  request; sampled only when `BUSY`=0.
- `OP`  in  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder).
- `OPERAND_A`  in  WIDTH  multiplicand/dividend (from `READ_DATA_1`).
- `OPERAND_B`  in  WIDTH  multiplier/divisor (from `READ_DATA_2`).
- `DEST_REG`  in  REG_ADDR_WIDTH  destination register index.
- `BUSY`  out  1  high from the edge after an accepted `START` until the write cycle completes.
- `WRITE_REG`  out  REG_ADDR_WIDTH  destination index; to the register file.
- `WRITE_DATA`  out  WIDTH  result; to the register file.
- `REG_WRITE_ENABLE`  out  1  one-cycle write strobe; to the register file.
- `DIV_BY_ZERO`  out  1  qualifier; high only together with `REG_WRITE_ENABLE` for DIV/REM with `OPERAND_B`=0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `START`=1, latch `OP`, `OPERAND_A`, `OPERAND_B`, `DEST_REG`; clear the iteration counter.
  - If `OP` is DIV or REM and `OPERAND_B`=0, go to DONE.
  - Otherwise go to RUN.
- RUN: perform one iteration per cycle for exactly WIDTH cycles, then go to DONE.
  - MUL/MULH: unsigned shift-add into a 2·WIDTH product. MUL returns bits [WIDTH-1:0]; MULH returns bits [2·WIDTH-1:WIDTH].
  - DIV/REM: unsigned restoring division with a (WIDTH+1)-bit partial remainder.
- DONE: assert `REG_WRITE_ENABLE` for exactly one cycle, with `WRITE_REG`=latched `DEST_REG` and `WRITE_DATA`=result; then go to IDLE.
- Divide by zero: quotient = all ones (0x3FFFF), remainder = `OPERAND_A`; `DIV_BY_ZERO`=1 during the DONE cycle.
- Operand values do not shorten RUN: zero operands and MUL with `OPERAND_B`=0 take the full latency.
- `DEST_REG`=0 has no special meaning; the write is issued normally.
- `START` while `BUSY`=1 (including the DONE cycle) is ignored and not queued.
- `OPERAND_A`, `OPERAND_B`, `OP` and `DEST_REG` may change freely after acceptance; only the latched copies are used.

## Timing
- Reset values on `CLEAR`: state IDLE; `BUSY`=0, `REG_WRITE_ENABLE`=0, `DIV_BY_ZERO`=0, `WRITE_DATA`=0, `WRITE_REG`=0; counter and datapath registers 0.
- `CLEAR` has priority over everything, including a same-edge `START`.
- `CLEAR` mid-operation aborts the operation: no write strobe is issued, and outputs hold reset values from the next cycle.
- `START` accepted at edge E0:
  - `BUSY`=1 after E0.
  - RUN iterations occur at edges E1..E18.
  - DONE is the cycle after E18: `REG_WRITE_ENABLE`=1, and the register file captures the result at E19.
  - After E19, `BUSY`=0.
  - Total latency is 19 cycles; `BUSY` is high for 19 cycles.
- Divide by zero: DONE is the cycle after E0; the write lands at E1 and `BUSY` is high for 1 cycle.
- `WRITE_REG` and `WRITE_DATA` hold the last result after the strobe until the next DONE or `CLEAR`; `DIV_BY_ZERO` returns to 0.
- Back-to-back: a `START` in the first cycle with `BUSY`=0 (after E19) is accepted; the peak issue rate is one operation per 20 cycles.

## Test plan
- MUL: `OPERAND_A`=3, `OPERAND_B`=5, `DEST_REG`=7 -> one `REG_WRITE_ENABLE` pulse 19 cycles after acceptance, `WRITE_DATA`=15, `WRITE_REG`=7, `BUSY` high for exactly 19 cycles.
- MUL/MULH: A=B=0x3FFFF -> MUL gives `WRITE_DATA`=0x00001; MULH gives `WRITE_DATA`=0x3FFFE.
- DIV/REM: A=100, B=7 -> DIV gives 14, REM gives 2; A=5, B=9 -> DIV gives 0, REM gives 5; `DIV_BY_ZERO`=0 in all cases.
- Divide by zero: A=0x12345, B=0 -> DIV writes 0x3FFFF and REM writes 0x12345, with `DIV_BY_ZERO`=1 during the strobe and the write 1 cycle after acceptance.
- Ignore and abort:
  - A `START` pulsed at cycles 3 and 18 of a busy operation changes nothing.
  - `CLEAR` at cycle 10 -> no strobe, and all outputs are 0 on the next cycle.
  - `START`+`CLEAR` on the same edge is not accepted.
  - A new `START` after `CLEAR` completes normally.
- Back-to-back: a second `START` (DIV 0x3FFFF/3) presented the first cycle `BUSY`=0 -> accepted; `WRITE_DATA`=0x15555 after 19 more cycles, with exactly two strobes total.
